// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported, variable-latency memory between the instruction
// fetch (IF) and data access (MEM) requesters. A request is served in three
// phases: grant in IDLE, bus transaction in BUSY_F/BUSY_D, and one RESP cycle
// in which the completion pulse is presented. Data accesses win over fetches.
// A fetch that is aborted while on the bus is still run to its ack, because a
// started transaction cannot be cancelled, but its result is discarded.
//
// Ports
//   clk, reset_x           clock (rising edge), async active-low reset
//   i_fetch*, o_fetch*     IF requester: req/addr/abort in, data/valid out
//   i_data*, o_data*       MEM requester: req/write/addr/wdata/size in,
//                          rdata/valid out
//   o_mem*, i_mem*         memory side: req/write/addr/wdata/size out,
//                          ack/rdata in
//   o_stallF, o_stallM     combinational stall requests to the hazard unit
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_x,
  input  logic              i_fetchReq,
  input  logic [ADDR_W-1:0] i_fetchAddr,
  input  logic              i_fetchAbort,
  output logic [DATA_W-1:0] o_fetchData,
  output logic              o_fetchValid,
  input  logic              i_dataReq,
  input  logic              i_dataWrite,
  input  logic [ADDR_W-1:0] i_dataAddr,
  input  logic [DATA_W-1:0] i_dataWdata,
  input  logic [1:0]        i_dataSize,
  output logic [DATA_W-1:0] o_dataRdata,
  output logic              o_dataValid,
  output logic              o_memReq,
  output logic              o_memWrite,
  output logic [ADDR_W-1:0] o_memAddr,
  output logic [DATA_W-1:0] o_memWdata,
  output logic [1:0]        o_memSize,
  input  logic              i_memAck,
  input  logic [DATA_W-1:0] i_memRdata,
  output logic              o_stallF,
  output logic              o_stallM
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_F = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [1:0] SIZE_WORD = 2'd2;

  state_t              state_q, state_d;
  logic                drop_q, drop_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [1:0]          mem_size_q, mem_size_d;
  logic [DATA_W-1:0]   fetch_data_q, fetch_data_d;
  logic                fetch_valid_q, fetch_valid_d;
  logic [DATA_W-1:0]   data_rdata_q, data_rdata_d;
  logic                data_valid_q, data_valid_d;

  // Grant decisions, only meaningful in IDLE. Data has priority; an abort in
  // the same cycle suppresses the fetch grant.
  logic grant_data, grant_fetch;
  assign grant_data  = i_dataReq;
  assign grant_fetch = ~i_dataReq & i_fetchReq & ~i_fetchAbort;

  // State and output registers
  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      state_q       <= IDLE;
      drop_q        <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_size_q    <= 2'd0;
      fetch_data_q  <= '0;
      fetch_valid_q <= 1'b0;
      data_rdata_q  <= '0;
      data_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      drop_q        <= drop_d;
      mem_req_q     <= mem_req_d;
      mem_write_q   <= mem_write_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_size_q    <= mem_size_d;
      fetch_data_q  <= fetch_data_d;
      fetch_valid_q <= fetch_valid_d;
      data_rdata_q  <= data_rdata_d;
      data_valid_q  <= data_valid_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_data) begin
          state_d = BUSY_D;
        end else if (grant_fetch) begin
          state_d = BUSY_F;
        end
      end
      BUSY_F, BUSY_D: begin
        if (i_memAck) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    drop_d        = drop_q;
    mem_req_d     = mem_req_q;
    mem_write_d   = mem_write_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_size_d    = mem_size_q;
    fetch_data_d  = fetch_data_q;
    fetch_valid_d = 1'b0;
    data_rdata_d  = data_rdata_q;
    data_valid_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_data) begin
          mem_req_d   = 1'b1;
          mem_write_d = i_dataWrite;
          mem_addr_d  = i_dataAddr;
          mem_wdata_d = i_dataWdata;
          mem_size_d  = i_dataSize;
        end else if (grant_fetch) begin
          mem_req_d   = 1'b1;
          mem_write_d = 1'b0;
          mem_addr_d  = i_fetchAddr;
          mem_size_d  = SIZE_WORD;
        end
      end
      BUSY_F: begin
        if (i_fetchAbort) begin
          drop_d = 1'b1;
        end
        if (i_memAck) begin
          mem_req_d = 1'b0;
          // An abort arriving together with the ack also discards the result.
          if (!(drop_q || i_fetchAbort)) begin
            fetch_valid_d = 1'b1;
            fetch_data_d  = i_memRdata;
          end
        end
      end
      BUSY_D: begin
        if (i_memAck) begin
          mem_req_d    = 1'b0;
          data_valid_d = 1'b1;
          // Stores complete without disturbing the last load result.
          if (!mem_write_q) begin
            data_rdata_d = i_memRdata;
          end
        end
      end
      RESP: begin
        drop_d = 1'b0;
      end
      default: begin
        drop_d = 1'b0;
      end
    endcase
  end

  assign o_fetchData  = fetch_data_q;
  assign o_fetchValid = fetch_valid_q;
  assign o_dataRdata  = data_rdata_q;
  assign o_dataValid  = data_valid_q;
  assign o_memReq     = mem_req_q;
  assign o_memWrite   = mem_write_q;
  assign o_memAddr    = mem_addr_q;
  assign o_memWdata   = mem_wdata_q;
  assign o_memSize    = mem_size_q;

  assign o_stallF = i_fetchReq & ~fetch_valid_q;
  assign o_stallM = i_dataReq & ~data_valid_q;

endmodule
